// File: rtl/cbus_err_pkg.sv
// Shared types and helpers for the CBUS access-timeout monitor.
// Imported by the per-channel monitor and the top level.
package cbus_err_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNT     = 2'd1,
    ST_ERR       = 2'd2,
    ST_WAIT_DROP = 2'd3
  } ch_state_e;

  localparam int CBUS_ERR_STRETCH_DEF = 6;
  localparam int CBUS_ERR_CNT_W_DEF   = 32;
  localparam int CBUS_ERR_MAX_CH      = 16;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] sum;
    sum = '0;
    for (int i = 0; i < 16; i++) begin
      sum = sum + 5'(v[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/cbus_err_ch.sv
// One monitored CBUS channel: enable synchroniser, timeout FSM, saturating
// age counter, error stretch counter and the dummy release pulse.
module cbus_err_ch
  import cbus_err_pkg::*;
#(
  parameter int CNT_W   = CBUS_ERR_CNT_W_DEF,
  parameter int STRETCH = CBUS_ERR_STRETCH_DEF
) (
  input  logic             cbus_clk,
  input  logic             cbus_rst_n,
  input  logic             req,
  input  logic             resp,
  input  logic [CNT_W-1:0] timeout_val,
  input  logic             err_cnt_en,
  output logic             access_err,
  output logic             dummy_rresp,
  output logic             dummy_waccept,
  output logic             fire
);

  localparam int SCNT_W = (STRETCH < 2) ? 1 : $clog2(STRETCH);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STRETCH - 1);

  ch_state_e         state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [SCNT_W-1:0] scnt, scnt_nxt;
  logic              dummy_r, dummy_nxt;
  logic              en_s;

  crg_sync2 #(.WIDTH(1)) u_en_sync (
    .clk   (cbus_clk),
    .rst_n (cbus_rst_n),
    .d     (err_cnt_en),
    .q     (en_s)
  );

  // A response arriving in the compare cycle suppresses the timeout.
  assign fire = (state == ST_COUNT) && en_s && req && !resp &&
                (timeout_val != '0) && (cnt >= timeout_val);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    scnt_nxt  = scnt;
    dummy_nxt = 1'b0;
    if (!en_s) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      scnt_nxt  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_nxt = '0;
          if (req && !resp) begin
            state_nxt = ST_COUNT;
            cnt_nxt   = CNT_W'(1);
          end
        end
        ST_COUNT: begin
          if (resp || !req) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else if (fire) begin
            state_nxt = ST_ERR;
            cnt_nxt   = '0;
            scnt_nxt  = '0;
          end else if (cnt != '1) begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_ERR: begin
          dummy_nxt = (scnt == '0);
          if (scnt == SCNT_LAST) begin
            state_nxt = ST_WAIT_DROP;
            scnt_nxt  = '0;
          end else begin
            scnt_nxt = scnt + SCNT_W'(1);
          end
        end
        ST_WAIT_DROP: begin
          if (!req) state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          scnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge cbus_clk or negedge cbus_rst_n) begin
    if (!cbus_rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      scnt    <= '0;
      dummy_r <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      scnt    <= scnt_nxt;
      dummy_r <= dummy_nxt;
    end
  end

  // Gating by en_s makes a disable take effect in the same cycle en_s drops.
  assign access_err    = (state == ST_ERR) && en_s;
  assign dummy_rresp   = dummy_r && en_s;
  assign dummy_waccept = dummy_r && en_s;

endmodule

// File: rtl/crg_sync2.sv
// Two-flop synchroniser for quasi-static control bits crossing into a clock domain.
// Resets to 0 so downstream logic starts disabled.
module crg_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cbus_err_mon.sv
// Multi-channel CBUS access-timeout monitor: per-channel monitors plus the
// shared sticky status, saturating error counter and interrupt.
module cbus_err_mon
  import cbus_err_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = CBUS_ERR_CNT_W_DEF,
  parameter int STRETCH  = CBUS_ERR_STRETCH_DEF,
  parameter int ERRCNT_W = 8
) (
  input  logic                cbus_clk,
  input  logic                cbus_rst_n,
  input  logic [NUM_CH-1:0]   cbus_m_req,
  input  logic [NUM_CH-1:0]   cbus_m_resp,
  input  logic [CNT_W-1:0]    bcfg_cbus_timeout_val,
  input  logic [NUM_CH-1:0]   bcfg_cbus_err_cnt_en,
  input  logic                bcfg_err_clr,
  output logic [NUM_CH-1:0]   cbus_access_err,
  output logic [NUM_CH-1:0]   dummy_cbus_rresp,
  output logic [NUM_CH-1:0]   dummy_cbus_waccept,
  output logic [NUM_CH-1:0]   cbus_err_sticky,
  output logic [ERRCNT_W-1:0] cbus_err_cnt,
  output logic                cbus_err_irq
);

  localparam int SUM_W = ERRCNT_W + 5;
  localparam logic [SUM_W-1:0] ERRCNT_MAX = SUM_W'({ERRCNT_W{1'b1}});

  logic [NUM_CH-1:0]          fire;
  logic [CBUS_ERR_MAX_CH-1:0] fire_ext;
  logic [4:0]                 fire_pop;
  logic [ERRCNT_W-1:0]        errcnt_base;
  logic [SUM_W-1:0]           errcnt_sum;
  logic [ERRCNT_W-1:0]        errcnt_nxt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    cbus_err_ch #(
      .CNT_W   (CNT_W),
      .STRETCH (STRETCH)
    ) u_ch (
      .cbus_clk      (cbus_clk),
      .cbus_rst_n    (cbus_rst_n),
      .req           (cbus_m_req[g]),
      .resp          (cbus_m_resp[g]),
      .timeout_val   (bcfg_cbus_timeout_val),
      .err_cnt_en    (bcfg_cbus_err_cnt_en[g]),
      .access_err    (cbus_access_err[g]),
      .dummy_rresp   (dummy_cbus_rresp[g]),
      .dummy_waccept (dummy_cbus_waccept[g]),
      .fire          (fire[g])
    );
  end

  // Clear zeroes the base first so a same-cycle fire still gets counted.
  always_comb begin
    fire_ext               = '0;
    fire_ext[NUM_CH-1:0]   = fire;
    fire_pop               = popcount16(fire_ext);
    errcnt_base            = bcfg_err_clr ? '0 : cbus_err_cnt;
    errcnt_sum             = SUM_W'(errcnt_base) + SUM_W'(fire_pop);
    errcnt_nxt             = (errcnt_sum > ERRCNT_MAX) ? '1 : errcnt_sum[ERRCNT_W-1:0];
  end

  always_ff @(posedge cbus_clk or negedge cbus_rst_n) begin
    if (!cbus_rst_n) begin
      cbus_err_sticky <= '0;
      cbus_err_cnt    <= '0;
      cbus_err_irq    <= 1'b0;
    end else begin
      cbus_err_sticky <= (cbus_err_sticky & ~{NUM_CH{bcfg_err_clr}}) | fire;
      cbus_err_cnt    <= errcnt_nxt;
      cbus_err_irq    <= |cbus_err_sticky;
    end
  end

endmodule

// File: tb/tb_cbus_err_mon.sv
// Bench for cbus_err_mon: directed table, hand sequences for multi-cycle
// corners, then randomized traffic against a behavioural model.
module tb_cbus_err_mon;

  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 32;
  localparam int STRETCH  = 6;
  localparam int ERRCNT_W = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NUM_CH-1:0]   req, resp, en;
  logic [CNT_W-1:0]    val;
  logic                clr;
  logic [NUM_CH-1:0]   err, rresp, waccept, sticky;
  logic [ERRCNT_W-1:0] ecnt;
  logic                irq;

  int n_tests = 0;
  int n_fail  = 0;

  cbus_err_mon #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .STRETCH(STRETCH), .ERRCNT_W(ERRCNT_W)
  ) dut (
    .cbus_clk              (clk),
    .cbus_rst_n            (rst_n),
    .cbus_m_req            (req),
    .cbus_m_resp           (resp),
    .bcfg_cbus_timeout_val (val),
    .bcfg_cbus_err_cnt_en  (en),
    .bcfg_err_clr          (clr),
    .cbus_access_err       (err),
    .dummy_cbus_rresp      (rresp),
    .dummy_cbus_waccept    (waccept),
    .cbus_err_sticky       (sticky),
    .cbus_err_cnt          (ecnt),
    .cbus_err_irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Hold mask for the timeout plus stretch, release, let channels settle.
  task automatic round(input logic [NUM_CH-1:0] mask, input int v);
    val = CNT_W'(v);
    req = mask;
    repeat (v + 1 + STRETCH + 2) tick();
    req = '0;
    repeat (2) tick();
  endtask

  // ---------------- behavioural reference model ----------------
  int unsigned m_age  [NUM_CH];  // cycles the current request has been timed, 0 = not timing
  bit          m_hold [NUM_CH];  // request already timed out, waiting for it to drop
  int          m_left [NUM_CH];  // remaining error-stretch cycles
  bit          m_dum  [NUM_CH];
  bit          m_en1  [NUM_CH];
  bit          m_en2  [NUM_CH];
  bit [NUM_CH-1:0] m_sticky;
  int          m_cnt;
  bit          m_irq;

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_age[i] = 0; m_hold[i] = 0; m_left[i] = 0; m_dum[i] = 0;
      m_en1[i] = 0; m_en2[i] = 0;
    end
    m_sticky = '0; m_cnt = 0; m_irq = 0;
  endfunction

  function automatic void model_step();
    bit [NUM_CH-1:0] fired;
    int nf;
    fired = '0;
    nf = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!m_en2[i]) begin
        m_age[i] = 0; m_hold[i] = 0; m_left[i] = 0; m_dum[i] = 0;
      end else if (m_left[i] > 0) begin
        m_dum[i] = (m_left[i] == STRETCH);
        m_left[i]--;
        if (m_left[i] == 0) m_hold[i] = 1;
      end else begin
        m_dum[i] = 0;
        if (m_hold[i]) begin
          if (!req[i]) m_hold[i] = 0;
        end else if (m_age[i] == 0) begin
          if (req[i] && !resp[i]) m_age[i] = 1;
        end else if (resp[i] || !req[i]) begin
          m_age[i] = 0;
        end else if (val != 0 && m_age[i] >= val) begin
          fired[i] = 1; nf++;
          m_age[i] = 0;
          m_left[i] = STRETCH;
        end else begin
          m_age[i]++;
        end
      end
      m_en2[i] = m_en1[i];
      m_en1[i] = en[i];
    end
    m_irq = |m_sticky;
    m_sticky = (clr ? '0 : m_sticky) | fired;
    m_cnt = (clr ? 0 : m_cnt) + nf;
    if (m_cnt > 255) m_cnt = 255;
  endfunction

  function automatic logic [63:0] model_outs();
    logic [NUM_CH-1:0] e, d;
    for (int i = 0; i < NUM_CH; i++) begin
      e[i] = (m_left[i] > 0) && m_en2[i];
      d[i] = m_dum[i] && m_en2[i];
    end
    return {27'd0, e, d, d, m_sticky, 8'(m_cnt), m_irq};
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    int unsigned v;
    int resp_at;
    int exp_rise;
    int exp_last;
    int exp_dum;
    int exp_inc;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int first, last, dum_at, n_rr, n_wa, low_at, n_dum, rises;
    logic prev;

    tbl[0] = '{10, -1, 11, 16, 12, 1};
    tbl[1] = '{10,  9, -1, -1, -1, 0};
    tbl[2] = '{10, 10, -1, -1, -1, 0};
    tbl[3] = '{ 1, -1,  2,  7,  3, 1};
    tbl[4] = '{ 3, -1,  4,  9,  5, 1};

    rst_n = 1'b0; req = '0; resp = '0; en = '0; val = '0; clr = 1'b0;
    repeat (2) tick();
    check("reset_outs", {err, rresp, waccept, sticky, ecnt, irq}, '0);
    rst_n = 1'b1;
    en = 4'b0001;
    repeat (3) tick();

    for (int r = 0; r < 5; r++) begin
      val = CNT_W'(tbl[r].v);
      req[0] = 1'b1; resp[0] = 1'b0;
      first = -1; last = -1; dum_at = -1; n_rr = 0; n_wa = 0;
      for (int c = 1; c <= 25; c++) begin
        tick();
        if (err[0]) begin
          if (first < 0) first = c;
          last = c;
        end
        if (rresp[0]) begin n_rr++; dum_at = c; end
        if (waccept[0]) n_wa++;
        resp[0] = (c == tbl[r].resp_at);
        req[0]  = !(tbl[r].resp_at >= 0 && c > tbl[r].resp_at);
      end
      req[0] = 1'b0; resp[0] = 1'b0;
      repeat (2) tick();
      check($sformatf("row%0d_rise", r), 64'(first), 64'(tbl[r].exp_rise));
      check($sformatf("row%0d_last", r), 64'(last), 64'(tbl[r].exp_last));
      check($sformatf("row%0d_dummy_at", r), 64'(dum_at), 64'(tbl[r].exp_dum));
      check($sformatf("row%0d_rresp_n", r), 64'(n_rr), 64'(tbl[r].exp_inc));
      check($sformatf("row%0d_waccept_n", r), 64'(n_wa), 64'(tbl[r].exp_inc));
      check($sformatf("row%0d_errcnt", r), 64'(ecnt), 64'(tbl[r].exp_inc));
      check($sformatf("row%0d_sticky", r), 64'(sticky), 64'(tbl[r].exp_inc));
      check($sformatf("row%0d_irq", r), 64'(irq), 64'(tbl[r].exp_inc));
      pulse_clr();
      check($sformatf("row%0d_clr_cnt", r), 64'(ecnt), 64'd0);
      check($sformatf("row%0d_clr_sticky", r), 64'(sticky), 64'd0);
      tick();
      check($sformatf("row%0d_clr_irq", r), 64'(irq), 64'd0);
    end

    // Disabled monitor never fires; lowering the threshold fires next compare.
    val = '0;
    req[0] = 1'b1;
    n_dum = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (err[0]) n_dum++;
    end
    check("val0_no_err", 64'(n_dum), 64'd0);
    val = CNT_W'(5);
    tick();
    check("val_lowered_fires", 64'(err[0]), 64'd1);
    repeat (STRETCH + 2) tick();
    req[0] = 1'b0;
    repeat (2) tick();
    pulse_clr();

    // Simultaneous timeouts, saturation, clear against a same-cycle fire.
    en = 4'hF;
    repeat (3) tick();
    val = CNT_W'(4);
    req = 4'b0101;
    repeat (5) tick();
    check("dual_err", 64'(err), 64'h5);
    check("dual_cnt", 64'(ecnt), 64'd2);
    repeat (STRETCH + 2) tick();
    req = '0;
    repeat (2) tick();
    pulse_clr();
    for (int k = 0; k < 63; k++) round(4'hF, 1);
    check("cnt_252", 64'(ecnt), 64'd252);
    round(4'b0101, 1);
    check("cnt_254", 64'(ecnt), 64'd254);
    round(4'b0101, 1);
    check("cnt_sat", 64'(ecnt), 64'd255);
    round(4'hF, 1);
    check("cnt_sat_hold", 64'(ecnt), 64'd255);
    val = CNT_W'(4);
    req = 4'b0010;
    repeat (4) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_fire_cnt", 64'(ecnt), 64'd1);
    check("clr_fire_sticky", 64'(sticky), 64'h2);
    repeat (STRETCH + 2) tick();
    req = '0;
    repeat (2) tick();
    pulse_clr();

    // Enable dropped in the fire cycle: error cut short, dummy suppressed.
    val = CNT_W'(10);
    req[1] = 1'b1;
    repeat (10) tick();
    en[1] = 1'b0;
    tick();
    check("en_drop_err_rise", 64'(err[1]), 64'd1);
    low_at = -1; n_dum = 0;
    for (int c = 12; c <= 16; c++) begin
      tick();
      if (!err[1] && low_at < 0) low_at = c;
      if (rresp[1] || waccept[1]) n_dum++;
    end
    check("en_drop_err_low", 64'(low_at > 0 && low_at <= 13), 64'd1);
    check("en_drop_no_dummy", 64'(n_dum), 64'd0);
    check("en_drop_sticky_kept", 64'(sticky[1]), 64'd1);
    req[1] = 1'b0;
    en[1] = 1'b1;
    repeat (3) tick();

    // A held request fires once; a fresh request fires again.
    val = CNT_W'(3);
    req[0] = 1'b1;
    rises = 0; prev = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (err[0] && !prev) rises++;
      prev = err[0];
    end
    check("held_req_one_err", 64'(rises), 64'd1);
    req[0] = 1'b0;
    repeat (2) tick();
    req[0] = 1'b1;
    rises = 0; prev = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (err[0] && !prev) rises++;
      prev = err[0];
    end
    check("reassert_err", 64'(rises), 64'd1);
    req[0] = 1'b0;
    repeat (2) tick();

    // Asynchronous reset mid-COUNT and mid-ERR.
    val = CNT_W'(5);
    req[0] = 1'b1;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_count", {err, rresp, waccept, sticky, ecnt, irq}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    first = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (err[0] && first < 0) first = c;
    end
    check("restart_rise", 64'(first), 64'd8);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_err", {err, rresp, waccept, sticky, ecnt, irq}, '0);
    req = '0;
    @(negedge clk);

    // Randomized traffic against the model.
    model_reset();
    en = 4'hF; val = CNT_W'(3); clr = 1'b0; resp = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        resp[i] = 1'b0;
        if (!req[i]) req[i] = ($urandom_range(0, 7) == 0);
        else if ($urandom_range(0, 29) == 0) req[i] = 1'b0;
        else resp[i] = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 199) == 0) en[i] = !en[i];
      end
      if ($urandom_range(0, 299) == 0) val = CNT_W'($urandom_range(0, 8));
      clr = ($urandom_range(0, 49) == 0);
      model_step();
      tick();
      check($sformatf("rand_c%0d", c), {27'd0, err, rresp, waccept, sticky, ecnt, irq},
            model_outs());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cbus_err_mon.md
Name: cbus_err_mon

Overview:
Multi-channel CBUS access-timeout monitor. It watches up to NUM_CH CBUS masters and flags any request held without response for bcfg_cbus_timeout_val cycles. On a timeout it asserts a stretched error, issues one-cycle dummy read-response/write-accept pulses to release the stalled master, and records sticky status, a saturating error count and an interrupt. It sits between the CBUS masters and the CRG config block.

Parameters:
NUM_CH, 4, number of monitored CBUS channels (1..16)
CNT_W, 32, timeout counter and timeout value width
STRETCH, 6, cycles cbus_access_err stays high per timeout (>=1)
ERRCNT_W, 8, width of saturating global error counter

Ports:
cbus_clk  in  1  CBUS clock
cbus_rst_n  in  1  asynchronous active-low reset
cbus_m_req  in  NUM_CH  per-channel access outstanding (level)
cbus_m_resp  in  NUM_CH  per-channel slave response/accept, terminates access
bcfg_cbus_timeout_val  in  CNT_W  shared timeout threshold; 0 = monitor disabled
bcfg_cbus_err_cnt_en  in  NUM_CH  per-channel enable, asynchronous to cbus_clk
bcfg_err_clr  in  1  single-cycle pulse, clears sticky status and error counter
cbus_access_err  out  NUM_CH  stretched timeout error
dummy_cbus_rresp  out  NUM_CH  one-cycle dummy read response
dummy_cbus_waccept  out  NUM_CH  one-cycle dummy write accept
cbus_err_sticky  out  NUM_CH  sticky per-channel timeout flag
cbus_err_cnt  out  ERRCNT_W  saturating count of timeouts, all channels
cbus_err_irq  out  1  registered OR of cbus_err_sticky

Behaviour:
- Clock and reset: one clock, cbus_clk. Reset is asynchronous and active-low on cbus_rst_n. On reset, all outputs, counters and FSMs go to 0 / IDLE.
- Enable sync: each bit of bcfg_cbus_err_cnt_en passes through a 2-flop synchroniser (en_s). Effective enable lags the input by 2 cycles.
- Per-channel FSM states: IDLE, COUNT, ERR, WAIT_DROP.
- IDLE: the counter is held at 0. If req & !resp & en_s, go to COUNT with cnt=1.
- COUNT: cnt increments each cycle while req & !resp. The counter saturates and never wraps.
  - resp=1 or req=0 -> IDLE, cnt=0.
  - Timeout fires when cnt >= timeout_val and timeout_val != 0 -> ERR.
  - If timeout_val is lowered mid-count below cnt, the timeout fires on the next compare.
- Simultaneous resp and timeout in the same cycle: resp wins, no error.
- ERR: cbus_access_err rises on the cycle after the fire. It stays high exactly STRETCH cycles, then the FSM goes to WAIT_DROP.
- Dummy pulses: dummy_cbus_rresp and dummy_cbus_waccept pulse high for one cycle, one cycle after cbus_access_err rises. They fire only if en_s is still set.
- WAIT_DROP: stays here until req=0, then IDLE. The same held request never fires twice. A resp in this state is ignored.
- en_s falls in any state: the FSM goes to IDLE next cycle, cbus_access_err and the dummy pulses drop immediately, and the counter clears. Sticky status and cbus_err_cnt are kept.
- Sticky status: cbus_err_sticky[i] sets on the fire event and clears on bcfg_err_clr. If set and clear happen in the same cycle, set wins.
- Error counter: cbus_err_cnt adds the popcount of fire events each cycle and saturates at all-ones. bcfg_err_clr zeroes it; a same-cycle fire then loads the popcount.
- cbus_err_irq is registered, one cycle after the sticky bit changes.
- Latency from req assertion (en_s stable, val=N>0) to cbus_access_err high: N+1 cycles.

Decomposition:
- Package cbus_err_pkg holds:
  - per-channel state enum (IDLE/COUNT/ERR/WAIT_DROP);
  - default constants CBUS_ERR_STRETCH_DEF=6 and CBUS_ERR_CNT_W_DEF=32;
  - a popcount function.
- Sub-module cbus_err_ch contains one channel's synchroniser (existing crg_sync2), FSM, counter, stretch counter and dummy pulse. It is instantiated NUM_CH times by generate.
- The top level owns sticky, global counter, clear and irq.

Test Plan:
1. val=10, en=1 on ch0, hold req, no resp -> cbus_access_err[0] high cycles 11..16 after req; dummy_cbus_rresp/waccept[0] single pulse at cycle 12; sticky[0]=1, cbus_err_cnt=1, irq=1.
2. val=10, resp at cycle 9 -> no error. Resp at the exact fire cycle -> no error, cnt=0 next cycle.
3. val=0 with req held 1000 cycles -> no error. Then val written 5 while cnt=20 -> error fires on the next compare.
4. ch0 and ch2 time out in the same cycle -> cbus_err_cnt +=2. Preload to 254 and fire 2 -> saturates at 255. bcfg_err_clr with a same-cycle fire on ch1 -> cnt=1, sticky=4'b0010.
5. en dropped during ERR -> access_err low within 3 cycles (sync), no dummy pulse if not yet issued. Req held through WAIT_DROP -> no second error until req drops and reasserts.
6. Assert cbus_rst_n low mid-COUNT and mid-ERR -> all outputs 0 asynchronously. After release with req held -> counting restarts from 0.
